prdecoder_stream: RTL and testbench

PRDECODER_STREAM -- requirements
Module: prdecoder_stream

---
 rtl/prdecoder_pkg.sv | 40 ++++
 rtl/prdecoder_skid.sv | 50 +++++
 rtl/prdecoder_stream.sv | 45 ++++
 tb/tb_prdecoder_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prdecoder_pkg.sv
// Shared constants, the mode encoding and the decode helpers for the
// prdecoder_stream block.
package prdecoder_pkg;

    localparam int CODE_W     = 3;
    localparam int WORD_W     = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = 1;
    localparam int CNT_W      = 2;

    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_THERM  = 1'b1
    } mode_e;

    // Thermometer is (onehot << 1) - 1; for k=7 the shift wraps to 0 and the
    // subtraction yields 8'hFF, which is exactly the required mask.
    function automatic logic [WORD_W-1:0] decode(input logic [CODE_W-1:0] code,
                                                 input mode_e            mode);
        logic [WORD_W-1:0] onehot;
        onehot = WORD_W'(1) << code;
        if (mode == MODE_THERM) begin
            decode = (onehot << 1) - WORD_W'(1);
        end else begin
            decode = onehot;
        end
    endfunction

    // 8-to-3 priority encoder: index of the highest set bit. Every word that
    // decode() produces maps back to its original code through this function.
    function automatic logic [CODE_W-1:0] prio_encode(input logic [WORD_W-1:0] word);
        prio_encode = '0;
        for (int i = 0; i < WORD_W; i++) begin
            if (word[i]) begin
                prio_encode = CODE_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/prdecoder_skid.sv
// Two-entry in-order FIFO holding decoded words; push/pop are pre-qualified
// by the caller (no push when full, no pop when empty).
module prdecoder_skid
    import prdecoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entries are cleared by reset, so the head reads 8'h00 while in reset.
    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/prdecoder_stream.sv
// Streaming 3-to-8 decoder (one-hot or thermometer) with a 2-entry output
// FIFO; words are decoded when written so storage holds 8-bit words.
module prdecoder_stream
    import prdecoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_mode,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out,
    input  logic              out_ready
);

    // Handshake: a transfer happens on a rising clk edge exactly when valid
    // and ready are both 1 on that side; valid never depends on ready, and
    // out/out_valid hold steady until the word is taken.
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] word;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign word      = decode(in_code, mode_e'(in_mode));

    prdecoder_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .pop_data  (out),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_prdecoder_stream.sv
// Self-checking bench for prdecoder_stream: queue scoreboard fed on accept,
// separate monitor popping on every output transfer.
module tb_prdecoder_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_mode;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out;
    logic       out_ready;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_pop = 0;

    logic [10:0] exp_q[$];   // {code, word}

    logic       lat_pend = 1'b0;
    logic [7:0] lat_word = '0;
    logic       hold_prev = 1'b0;
    logic [7:0] prev_out = '0;

    prdecoder_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_mode   (in_mode),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out       (out),
        .out_ready (out_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_word(input logic [2:0] code, input logic mode);
        int k;
        int v;
        k = int'(code);
        if (mode) v = (2 ** (k + 1)) - 1;
        else      v = 2 ** k;
        return v[7:0];
    endfunction

    function automatic logic [2:0] model_enc(input logic [7:0] w);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w[i]) begin
                r = 3'(i);
                break;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic m, input logic r);
        in_valid  = v;
        in_code   = c;
        in_mode   = m;
        out_ready = r;
    endtask

    // ---------------- accept watcher (scoreboard producer) ----------------
    always @(negedge clk) begin
        logic [7:0] w;
        if (rst_n) begin
            if (lat_pend) begin
                check("latency_valid", 32'(out_valid), 32'd1);
                check("latency_word", 32'(out), 32'(lat_word));
                lat_pend = 1'b0;
            end
            if (in_valid && in_ready) begin
                w = model_word(in_code, in_mode);
                exp_q.push_back({in_code, w});
                n_acc++;
                if (!out_valid) begin
                    lat_pend = 1'b1;
                    lat_word = w;
                end
            end
        end else begin
            lat_pend = 1'b0;
        end
    end

    // ---------------- monitor (scoreboard consumer) ----------------
    always @(negedge clk) begin
        logic [10:0] e;
        if (rst_n) begin
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_word", 32'(out), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 32'(out), 32'(e[7:0]));
                    check("encode", 32'(model_enc(out)), 32'(e[10:8]));
                end
                n_pop++;
            end
            hold_prev = out_valid && !out_ready;
            prev_out  = out;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc0;
        int pop0;

        rst_n = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Exhaustive decode; first code offered as reset releases.
        drive(1'b1, 3'd0, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 8; c++) begin
                drive(1'b1, 3'(c), 1'(m), 1'b1);
                step();
            end
        end
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        step();
        step();
        check("exh_accepts", 32'(n_acc), 32'd16);
        check("exh_pops", 32'(n_pop), 32'd16);

        // Backpressure: fill with codes 2 and 6, try a third.
        acc0 = n_acc;
        drive(1'b1, 3'd2, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'd6, 1'b0, 1'b0);
        step();
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out), 32'h04);
        drive(1'b1, 3'd3, 1'b1, 1'b0);
        step();
        step();
        check("bp_no_third", 32'(n_acc - acc0), 32'd2);
        check("bp_head_held", 32'(out), 32'h04);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        step();
        check("bp_second", 32'(out), 32'h40);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Simultaneous push and pop at count=1.
        drive(1'b1, 3'd0, 1'b1, 1'b0);
        step();
        check("sim_head", 32'(out), 32'h01);
        drive(1'b1, 3'd7, 1'b1, 1'b1);
        step();
        check("sim_valid", 32'(out_valid), 32'd1);
        check("sim_in_ready", 32'(in_ready), 32'd1);
        check("sim_word", 32'(out), 32'hFF);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        step();
        check("sim_count1", 32'(out_valid), 32'd0);

        // Throughput: 100 codes back to back.
        acc0 = n_acc;
        pop0 = n_pop;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
            step();
            check("tp_in_ready", 32'(in_ready), 32'd1);
            check("tp_no_bubble", 32'(out_valid), 32'd1);
        end
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        step();
        step();
        check("tp_accepts", 32'(n_acc - acc0), 32'd100);
        check("tp_pops", 32'(n_pop - pop0), 32'd100);

        // Random valid/ready toggling.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        repeat (4) step();
        check("rand_balance", 32'(n_pop), 32'(n_acc));
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream with two words held.
        drive(1'b1, 3'd4, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'd5, 1'b1, 1'b0);
        step();
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        step();
        check("post_rst_no_stale", 32'(out_valid), 32'd0);
        drive(1'b1, 3'd1, 1'b1, 1'b1);
        step();
        check("post_rst_word", 32'(out), 32'h03);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        repeat (3) step();
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
